wts_host_bridge: RTL

Bus initiator that drives the wave-table sound core's register interface (wrreq/rdreq, wr_active/rd_active, a, d, q) from a valid/ready command stream. Commands are buffered in a small FIFO, then serialised into fixed-length bus accesses. Read data is returned on a valid/ready response channel. It sits between a host CPU or sequencer and the sound core, and is used by the core-level bench and the FPGA top as the canonical register master.

---
 rtl/wts_host_bridge_pkg.sv | 22 ++
 rtl/wts_host_bridge_fifo.sv | 52 +++++
 rtl/wts_host_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/wts_host_bridge_pkg.sv
// rtl/wts_host_bridge_pkg.sv - shared FSM encoding and command field layout for the host bridge
package wts_host_bridge_pkg;

  localparam int CMD_W       = 24;
  localparam int CMD_RW_BIT  = 23;
  localparam int CMD_ADDR_HI = 22;
  localparam int CMD_ADDR_LO = 8;
  localparam int CMD_DATA_HI = 7;
  localparam int CMD_DATA_LO = 0;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_RESP,
    ST_GAP
  } state_t;

endpackage

// File: rtl/wts_host_bridge_fifo.sv
// rtl/wts_host_bridge_fifo.sv - first-word-fall-through command FIFO with full/empty flags
module wts_host_bridge_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wts_host_bridge.sv
// rtl/wts_host_bridge.sv - command-stream master for the wave-table sound core register bus
// Optional counters under WTS_HOST_BRIDGE_PERF_EN.
module wts_host_bridge
  import wts_host_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ACCESS_CYCLES = 3,
  parameter int GAP_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [14:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        wrreq,
  output logic        rdreq,
  output logic        wr_active,
  output logic        rd_active,
  output logic [14:0] a,
  output logic [7:0]  d,
  input  logic [7:0]  q,
  input  logic        nint,
  output logic        irq
`ifdef WTS_HOST_BRIDGE_PERF_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] stall_count
`endif
);

  localparam int CNT_W = 16;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rw_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [CMD_W-1:0] head;
  logic             last_active;

  wts_host_bridge_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_rw, cmd_addr, cmd_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign pop         = (state == ST_IDLE) && !fifo_empty;
  assign busy        = !fifo_empty || (state != ST_IDLE);
  assign last_active = ((state == ST_REQ) && (ACCESS_CYCLES == 1)) ||
                       ((state == ST_HOLD) && (cnt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rw_q      <= CMD_WRITE;
      wrreq     <= 1'b0;
      rdreq     <= 1'b0;
      wr_active <= 1'b0;
      rd_active <= 1'b0;
      a         <= '0;
      d         <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            rw_q      <= head[CMD_RW_BIT];
            a         <= head[CMD_ADDR_HI:CMD_ADDR_LO];
            d         <= head[CMD_DATA_HI:CMD_DATA_LO];
            wrreq     <= (head[CMD_RW_BIT] == CMD_WRITE);
            wr_active <= (head[CMD_RW_BIT] == CMD_WRITE);
            rdreq     <= (head[CMD_RW_BIT] == CMD_READ);
            rd_active <= (head[CMD_RW_BIT] == CMD_READ);
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          wrreq <= 1'b0;
          rdreq <= 1'b0;
          if (ACCESS_CYCLES > 1) begin
            state <= ST_HOLD;
            cnt   <= CNT_W'(ACCESS_CYCLES - 2);
          end
        end
        ST_HOLD: cnt <= cnt - 1'b1;
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= ST_GAP;
              cnt   <= CNT_W'(GAP_CYCLES - 1);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      // Shared end-of-window action; overrides the per-state next state above.
      if (last_active) begin
        wr_active <= 1'b0;
        rd_active <= 1'b0;
        if (rw_q == CMD_READ) begin
          rsp_data  <= q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end else if (GAP_CYCLES > 0) begin
          state <= ST_GAP;
          cnt   <= CNT_W'(GAP_CYCLES - 1);
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= ~nint;
  end

`ifdef WTS_HOST_BRIDGE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count    <= '0;
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if ((state == ST_REQ) && (rw_q == CMD_WRITE)) wr_count <= wr_count + 1'b1;
      if ((state == ST_REQ) && (rw_q == CMD_READ))  rd_count <= rd_count + 1'b1;
      if (cmd_valid && !cmd_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule
